// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 device-side responder: command bytes,
// command-type field values, FSM state enum and the key-scan byte mapping.
package tm1638_pkg;

  localparam logic [7:0] C_READ_KEYS  = 8'h42;
  localparam logic [7:0] C_WRITE_DISP = 8'h40;
  localparam logic [7:0] C_SET_ADDR_0 = 8'hC0;
  localparam logic [7:0] C_DISPLAY_ON = 8'h8F;

  // Command type lives in bits [7:6] of the first byte of a frame
  localparam logic [1:0] CMD_TYPE_NONE = 2'b00;
  localparam logic [1:0] CMD_TYPE_DATA = 2'b01;
  localparam logic [1:0] CMD_TYPE_DISP = 2'b10;
  localparam logic [1:0] CMD_TYPE_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } tm1638_rsp_state_t;

  // Four scan bytes packed as {b3, b2, b1, b0}; b0 is shifted out first
  function automatic logic [31:0] key_scan(input logic [7:0] keys);
    return {3'b000, keys[0], 3'b000, keys[4],
            3'b000, keys[1], 3'b000, keys[5],
            3'b000, keys[2], 3'b000, keys[6],
            3'b000, keys[3], 3'b000, keys[7]};
  endfunction

endpackage

// File: rtl/tm1638_responder_sio.sv
// Two-flop synchronizer for the host STB/CLK/DIO lines, with a third stage
// on CLK and STB producing single-cycle rise/fall pulses.
module tm1638_sio_sync (
  input  logic clk,
  input  logic rst,
  input  logic sio_clk,
  input  logic sio_stb,
  input  logic sio_data_in,
  output logic clk_rise,
  output logic clk_fall,
  output logic stb_rise,
  output logic stb_fall,
  output logic stb_level,
  output logic data_bit
);

  logic [2:0] clk_sync_reg;
  logic [2:0] stb_sync_reg;
  logic [1:0] data_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 3'b111;
      stb_sync_reg  <= 3'b111;
      data_sync_reg <= 2'b00;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[1:0], sio_clk};
      stb_sync_reg  <= {stb_sync_reg[1:0], sio_stb};
      data_sync_reg <= {data_sync_reg[0], sio_data_in};
    end
  end

  assign clk_rise  = clk_sync_reg[1] & ~clk_sync_reg[2];
  assign clk_fall  = ~clk_sync_reg[1] & clk_sync_reg[2];
  assign stb_rise  = stb_sync_reg[1] & ~stb_sync_reg[2];
  assign stb_fall  = ~stb_sync_reg[1] & stb_sync_reg[2];
  assign stb_level = stb_sync_reg[1];
  assign data_bit  = data_sync_reg[1];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes host commands, holds display RAM and
// returns key scans. Optional protocol-error pulse: TM1638_RESPONDER_PROTO_CHECK_EN.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int clk_mhz = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sio_clk,
  input  logic            sio_stb,
  input  logic            sio_data_in,
  output logic            sio_data_out,
  output logic            sio_data_out_en,
  input  logic [7:0]      keys,
  output logic [15:0][7:0] disp_ram,
  output logic            display_on,
  output logic [2:0]      brightness,
  output logic            frame_done
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
  ,
  output logic            proto_err
`endif
);

  logic clk_rise, clk_fall, stb_rise, stb_fall, stb_level, data_bit;

  tm1638_sio_sync u_sio_sync (
    .clk        (clk),
    .rst        (rst),
    .sio_clk    (sio_clk),
    .sio_stb    (sio_stb),
    .sio_data_in(sio_data_in),
    .clk_rise   (clk_rise),
    .clk_fall   (clk_fall),
    .stb_rise   (stb_rise),
    .stb_fall   (stb_fall),
    .stb_level  (stb_level),
    .data_bit   (data_bit)
  );

  tm1638_rsp_state_t state_reg, state_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [6:0]        shift_reg, shift_next;
  logic [3:0]        addr_reg, addr_next;
  logic              rd_mode_reg, rd_mode_next;
  logic              fixed_reg, fixed_next;
  logic              display_on_reg, display_on_next;
  logic [2:0]        brightness_reg, brightness_next;
  logic [31:0]       scan_reg, scan_next;
  logic [2:0]        rd_byte_reg, rd_byte_next;
  logic              wrote_reg, wrote_next;
  logic              armed_reg, armed_next;
  logic [1:0]        settle_reg, settle_next;
  logic              data_out_reg, data_out_next;
  logic              data_out_en_reg, data_out_en_next;
  logic              frame_done_reg, frame_done_next;
  logic [15:0][7:0]  disp_ram_reg;
  logic              ram_we;
  logic [3:0]        ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        rx_byte;
  logic              byte_done;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
  logic              proto_err_reg, proto_err_next;
`endif

  assign rx_byte   = {data_bit, shift_reg};
  assign byte_done = clk_rise && (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      addr_reg        <= '0;
      rd_mode_reg     <= 1'b0;
      fixed_reg       <= 1'b0;
      display_on_reg  <= 1'b0;
      brightness_reg  <= '0;
      scan_reg        <= '0;
      rd_byte_reg     <= '0;
      wrote_reg       <= 1'b0;
      armed_reg       <= 1'b0;
      settle_reg      <= '0;
      data_out_reg    <= 1'b0;
      data_out_en_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      disp_ram_reg    <= '0;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
      proto_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      addr_reg        <= addr_next;
      rd_mode_reg     <= rd_mode_next;
      fixed_reg       <= fixed_next;
      display_on_reg  <= display_on_next;
      brightness_reg  <= brightness_next;
      scan_reg        <= scan_next;
      rd_byte_reg     <= rd_byte_next;
      wrote_reg       <= wrote_next;
      armed_reg       <= armed_next;
      settle_reg      <= settle_next;
      data_out_reg    <= data_out_next;
      data_out_en_reg <= data_out_en_next;
      frame_done_reg  <= frame_done_next;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
      proto_err_reg   <= proto_err_next;
`endif
      if (ram_we) disp_ram_reg[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    addr_next        = addr_reg;
    rd_mode_next     = rd_mode_reg;
    fixed_next       = fixed_reg;
    display_on_next  = display_on_reg;
    brightness_next  = brightness_reg;
    scan_next        = scan_reg;
    rd_byte_next     = rd_byte_reg;
    wrote_next       = wrote_reg;
    data_out_next    = data_out_reg;
    data_out_en_next = data_out_en_reg;
    frame_done_next  = 1'b0;
    ram_we           = 1'b0;
    ram_waddr        = addr_reg;
    ram_wdata        = rx_byte;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
    proto_err_next   = 1'b0;
`endif
    // After reset the synchronizer may report a stale STB fall while the host
    // is mid-frame; only accept a new frame once STB has been seen high.
    settle_next = (settle_reg == 2'd3) ? settle_reg : settle_reg + 2'd1;
    armed_next  = armed_reg | ((settle_reg == 2'd3) & stb_level);

    if (stb_rise) begin
      state_next       = ST_IDLE;
      bit_cnt_next     = '0;
      data_out_next    = 1'b0;
      data_out_en_next = 1'b0;
      frame_done_next  = wrote_reg;
      wrote_next       = 1'b0;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
      proto_err_next   = (bit_cnt_reg != 3'd0);
`endif
    end else begin
      if (clk_rise && (state_reg != ST_IDLE)) begin
        shift_next   = rx_byte[7:1];
        bit_cnt_next = bit_cnt_reg + 3'd1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (stb_fall && armed_reg) begin
            state_next   = ST_CMD;
            bit_cnt_next = '0;
            wrote_next   = 1'b0;
          end
        end
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte[7:6])
              CMD_TYPE_DATA: begin
                rd_mode_next = rx_byte[1];
                fixed_next   = rx_byte[2];
                if (rx_byte[1]) begin
                  state_next       = ST_READ;
                  scan_next        = key_scan(keys);
                  rd_byte_next     = '0;
                  data_out_en_next = 1'b1;
                end else begin
                  state_next = ST_IGNORE;
                end
              end
              CMD_TYPE_ADDR: begin
                addr_next  = rx_byte[3:0];
                state_next = ST_WRITE;
              end
              CMD_TYPE_DISP: begin
                display_on_next = rx_byte[3];
                brightness_next = rx_byte[2:0];
                state_next      = ST_IGNORE;
              end
              default: begin
                state_next = ST_IGNORE;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
                proto_err_next = 1'b1;
`endif
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (byte_done) begin
            ram_we     = 1'b1;
            wrote_next = 1'b1;
            if (!fixed_reg) addr_next = addr_reg + 4'd1;
          end
        end
        ST_READ: begin
          // Bit index is {byte, bit}; past b3 the link carries zeros
          if (clk_fall && rd_mode_reg)
            data_out_next = rd_byte_reg[2] ? 1'b0 : scan_reg[{rd_byte_reg[1:0], bit_cnt_reg}];
          if (byte_done && !rd_byte_reg[2]) rd_byte_next = rd_byte_reg + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign disp_ram        = disp_ram_reg;
  assign display_on      = display_on_reg;
  assign brightness      = brightness_reg;
  assign sio_data_out    = data_out_reg;
  assign sio_data_out_en = data_out_en_reg;
  assign frame_done      = frame_done_reg;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
  assign proto_err       = proto_err_reg;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: directed protocol scenarios plus
// randomized frames checked against a transaction-level model.
module tb_tm1638_responder;
  import tm1638_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sio_clk = 1'b1;
  logic             sio_stb = 1'b1;
  logic             sio_data_in = 1'b0;
  logic [7:0]       keys = 8'h00;
  logic             sio_data_out;
  logic             sio_data_out_en;
  logic [15:0][7:0] disp_ram;
  logic             display_on;
  logic [2:0]       brightness;
  logic             frame_done;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
  logic             proto_err;
  int               pe_count = 0;
`endif

  tm1638_responder #(.clk_mhz(50)) dut (
    .clk            (clk),
    .rst            (rst),
    .sio_clk        (sio_clk),
    .sio_stb        (sio_stb),
    .sio_data_in    (sio_data_in),
    .sio_data_out   (sio_data_out),
    .sio_data_out_en(sio_data_out_en),
    .keys           (keys),
    .disp_ram       (disp_ram),
    .display_on     (display_on),
    .brightness     (brightness),
    .frame_done     (frame_done)
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
    ,
    .proto_err      (proto_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_count++;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
    if (proto_err === 1'b1) pe_count++;
`endif
  end

  // Transaction-level reference model
  logic [15:0][7:0] m_ram;
  logic [3:0]       m_addr;
  logic             m_fixed;
  logic             m_disp_on;
  logic [2:0]       m_bright;
  int               m_fd;
  logic [7:0]       tx_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ram = '0; m_addr = '0; m_fixed = 1'b0; m_disp_on = 1'b0; m_bright = '0;
  endtask

  task automatic model_frame();
    logic [7:0] cmd;
    bit wrote;
    wrote = 0;
    if (tx_q.size() == 0) return;
    cmd = tx_q[0];
    case (cmd[7:6])
      2'b01: m_fixed = cmd[2];
      2'b10: begin m_disp_on = cmd[3]; m_bright = cmd[2:0]; end
      2'b11: begin
        m_addr = cmd[3:0];
        for (int i = 1; i < tx_q.size(); i++) begin
          m_ram[m_addr] = tx_q[i];
          wrote = 1;
          if (!m_fixed) m_addr = m_addr + 4'd1;
        end
      end
      default: ;
    endcase
    if (wrote) m_fd++;
  endtask

  function automatic logic [7:0] exp_key_byte(input logic [7:0] k, input int j);
    logic [7:0] r;
    r = 8'h00;
    if (j < 4) begin
      r[0] = k[7 - j];
      r[4] = k[3 - j];
    end
    return r;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sio_clk = 1'b0; sio_data_in = b; wait_clk(6);
    sio_clk = 1'b1; wait_clk(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic read_byte(output logic [7:0] b);
    sio_data_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sio_clk = 1'b0; wait_clk(6);
      b[i] = sio_data_out;
      sio_clk = 1'b1; wait_clk(6);
    end
  endtask

  task automatic frame_start();
    sio_stb = 1'b0; wait_clk(6);
  endtask

  task automatic frame_end();
    sio_stb = 1'b1; wait_clk(8);
  endtask

  task automatic send_frame();
    frame_start();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    frame_end();
    model_frame();
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ram"}, disp_ram, m_ram);
    chk({tag, "_frame_done"}, fd_count, m_fd);
    chk({tag, "_disp_on"}, display_on, m_disp_on);
    chk({tag, "_bright"}, brightness, m_bright);
  endtask

  task automatic read_frame(input int nbytes);
    logic [7:0] got;
    frame_start();
    send_byte(C_READ_KEYS);
    m_fixed = 1'b0;
    for (int j = 0; j < nbytes; j++) begin
      read_byte(got);
      if (j == 0) chk("read_en_high", sio_data_out_en, 1'b1);
      chk($sformatf("key_byte%0d_k%02h", j, keys), got, exp_key_byte(keys, j));
    end
    frame_end();
    chk("read_en_low", sio_data_out_en, 1'b0);
  endtask

  task automatic write_mode(input logic fixed);
    tx_q = {C_WRITE_DISP | {5'b0, fixed, 2'b0}};
    send_frame();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, n;
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
    int pe_base;
`endif
    model_reset();
    m_fd = 0;
    wait_clk(5);
    chk("rst_ram", disp_ram, 128'h0);
    chk("rst_disp_on", display_on, 1'b0);
    chk("rst_bright", brightness, 3'd0);
    chk("rst_out", sio_data_out, 1'b0);
    chk("rst_out_en", sio_data_out_en, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    wait_clk(6);

    // Auto-increment write of the whole RAM
    write_mode(1'b0);
    tx_q = {C_SET_ADDR_0};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    send_frame();
    check_model("autoinc");
    chk("autoinc_one_pulse", fd_count, 1);

    // Fixed-address write
    write_mode(1'b1);
    tx_q = {8'hC5, 8'hAA, 8'hBB};
    send_frame();
    check_model("fixed");

    // Address wrap from 15 to 0
    write_mode(1'b0);
    tx_q = {8'hCF, 8'h11, 8'h22};
    send_frame();
    check_model("wrap");

    // Display control then key read with trailing zero byte
    tx_q = {C_DISPLAY_ON};
    send_frame();
    check_model("dispctl");
    keys = 8'h81;
    read_frame(5);

    // Partial data byte is discarded
    write_mode(1'b0);
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
    pe_base = pe_count;
`endif
    frame_start();
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    frame_end();
    tx_q = {8'hC3};
    model_frame();
    check_model("partial");
`ifdef TM1638_RESPONDER_PROTO_CHECK_EN
    chk("partial_proto_err", pe_count - pe_base, 1);
    tx_q = {8'h00};
    send_frame();
    chk("cmd00_proto_err", pe_count - pe_base, 2);
`endif
    tx_q = {8'hC3, 8'h5A};
    send_frame();
    check_model("after_partial");

    // Randomized frames
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        write_mode(1'($urandom));
        n = $urandom_range(1, 6);
        tx_q = {C_SET_ADDR_0 | 8'($urandom_range(0, 15))};
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        send_frame();
      end else if (kind == 1) begin
        tx_q = {8'h80 | 8'($urandom_range(0, 15))};
        send_frame();
      end else begin
        keys = 8'($urandom);
        read_frame(5);
      end
      check_model($sformatf("rand%0d", it));
    end

    // Reset in the middle of a write burst
    write_mode(1'b0);
    frame_start();
    send_byte(C_SET_ADDR_0);
    send_byte(8'h77);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    model_reset();
    chk("midrst_ram", disp_ram, 128'h0);
    chk("midrst_disp_on", display_on, 1'b0);
    chk("midrst_bright", brightness, 3'd0);
    chk("midrst_out_en", sio_data_out_en, 1'b0);
    chk("midrst_out", sio_data_out, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_byte(8'h99);
    frame_end();
    check_model("midrst_tail");
    tx_q = {8'hC2, 8'h33};
    send_frame();
    check_model("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
